// File: rtl/gexor_pkg.sv
// ============================================================================
// Module   : gexor_pkg
// Purpose  : Shared constants and FSM state type for the bit-serial XOR block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gexor_pkg;

    localparam int CNT_W = 6;
    localparam int W_MAX = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gexor_seq_if.sv
// ============================================================================
// Module   : gexor_seq_if
// Purpose  : Word-level request/result bundle between requester and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gexor_seq_if #(
    parameter int W = 8
);

    logic         start;
    logic         clear;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         parity;

    modport master (
        output start, clear, a_in, b_in,
        input  ready, busy, done, y, parity
    );

    modport slave (
        input  start, clear, a_in, b_in,
        output ready, busy, done, y, parity
    );

endinterface

`default_nettype wire

// File: rtl/gexor.sv
// ============================================================================
// Module   : gexor
// Purpose  : Single-bit XOR gate; the sole datapath element of gexor_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gexor (
    input  wire logic a,
    input  wire logic b,
    output logic      c
);

    assign c = a ^ b;

endmodule

`default_nettype wire

// File: rtl/gexor_seq.sv
// ============================================================================
// Module   : gexor_seq
// Purpose  : Steps two W-bit operands LSB-first through one gexor gate and
//            publishes the W-bit result plus its XOR-reduction parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gexor_seq
    import gexor_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    gexor_seq_if.slave       bus
);

    state_t           r_state;
    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_y_sh;
    logic             r_par_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_y;
    logic             r_parity;
    logic             r_done;
    logic             r_ready;
    logic             r_busy;

    logic             w_c;
    logic [W-1:0]     w_y_next;
    logic             w_last;

    gexor u_gexor (
        .a (r_a_sh[0]),
        .b (r_b_sh[0]),
        .c (w_c)
    );

    // Shifting {c, y_sh} right and truncating drops y_sh[0] and also covers W=1.
    assign w_y_next = W'({w_c, r_y_sh} >> 1);
    assign w_last   = (r_cnt == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_y_sh    <= '0;
            r_par_acc <= 1'b0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_parity  <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.clear) begin
                        r_state   <= ST_RUN;
                        r_a_sh    <= bus.a_in;
                        r_b_sh    <= bus.b_in;
                        r_y_sh    <= '0;
                        r_par_acc <= 1'b0;
                        r_cnt     <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.clear) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_a_sh    <= r_a_sh >> 1;
                        r_b_sh    <= r_b_sh >> 1;
                        r_y_sh    <= w_y_next;
                        r_par_acc <= r_par_acc ^ w_c;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state  <= ST_IDLE;
                            r_y      <= w_y_next;
                            r_parity <= r_par_acc ^ w_c;
                            r_done   <= 1'b1;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.y      = r_y;
    assign bus.parity = r_parity;

endmodule

`default_nettype wire

// File: tb/tb_gexor_seq.sv
// ============================================================================
// Module   : tb_gexor_seq
// Purpose  : Directed self-checking bench for gexor_seq with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gexor_seq;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    gexor_seq_if #(.W(W)) bus ();

    gexor_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Word-level model: an operation is just "W cycles remaining", then y = a ^ b.
    int           m_left   = 0;
    logic [W-1:0] m_a      = '0;
    logic [W-1:0] m_b      = '0;
    logic [W-1:0] m_y      = '0;
    logic         m_parity = 1'b0;
    logic         m_done   = 1'b0;

    always @(negedge rst_n) begin
        m_left = 0; m_y = '0; m_parity = 1'b0; m_done = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (bus.clear) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_y      = m_a ^ m_b;
                        m_parity = ^(m_a ^ m_b);
                        m_done   = 1'b1;
                    end
                end
            end else if (bus.start && !bus.clear) begin
                m_left = W;
                m_a    = bus.a_in;
                m_b    = bus.b_in;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",  {31'd0, bus.ready},  {31'd0, m_left == 0});
        chk("busy",   {31'd0, bus.busy},   {31'd0, m_left != 0});
        chk("done",   {31'd0, bus.done},   {31'd0, m_done});
        chk("y",      {24'd0, bus.y},      {24'd0, m_y});
        chk("parity", {31'd0, bus.parity}, {31'd0, m_parity});
    end

    // Called one negedge after acceptance; n counts RUN edges seen so far.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.done) break;
            if (n > 40) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("accepted", {31'd0, bus.busy}, 32'd1);
    endtask

    int n;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.clear = 1'b0;
        bus.a_in  = 8'hA5;
        bus.b_in  = 8'h0F;

        // Reset held with start asserted: nothing accepted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready",  {31'd0, bus.ready},  32'd1);
            chk("rst_busy",   {31'd0, bus.busy},   32'd0);
            chk("rst_done",   {31'd0, bus.done},   32'd0);
            chk("rst_y",      {24'd0, bus.y},      32'h00);
            chk("rst_parity", {31'd0, bus.parity}, 32'd0);
        end

        // Release with start still high: accepted at the very first edge.
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_edge_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(0, n);
        chk("lat_a5", n, W);
        chk("y_a5",   {24'd0, bus.y}, 32'hAA);
        chk("p_a5",   {31'd0, bus.parity}, 32'd0);

        // Back-to-back in the done cycle, with a stray start mid-RUN.
        accept(8'hFF, 8'hFF);
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'h00; bus.b_in = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, n);
        chk("lat_ff", n, W);
        chk("y_ff",   {24'd0, bus.y}, 32'h00);
        chk("p_ff",   {31'd0, bus.parity}, 32'd0);

        // Truth-table coverage.
        accept(8'h0D, 8'h0A);
        wait_done(0, n);
        chk("lat_0d", n, W);
        chk("y_0d",   {24'd0, bus.y}, 32'h07);
        chk("p_0d",   {31'd0, bus.parity}, 32'd1);
        @(negedge clk);

        // Clear during the 5th RUN cycle.
        accept(8'h55, 8'hF0);
        repeat (4) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clr_ready", {31'd0, bus.ready}, 32'd1);
        chk("clr_done",  {31'd0, bus.done},  32'd0);
        chk("clr_y",     {24'd0, bus.y},     32'h07);
        repeat (10) @(negedge clk);

        // Clear and start together in IDLE.
        bus.clear = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.start = 1'b0;
        chk("clr_start_idle", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);

        // Asynchronous reset pulse between edges mid-RUN.
        accept(8'h12, 8'h34);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready",  {31'd0, bus.ready},  32'd1);
        chk("arst_busy",   {31'd0, bus.busy},   32'd0);
        chk("arst_done",   {31'd0, bus.done},   32'd0);
        chk("arst_y",      {24'd0, bus.y},      32'h00);
        chk("arst_parity", {31'd0, bus.parity}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        accept(8'h3C, 8'hFF);
        wait_done(0, n);
        chk("lat_3c", n, W);
        chk("y_3c",   {24'd0, bus.y}, 32'hC3);
        chk("p_3c",   {31'd0, bus.parity}, 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
